// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2^IDX_W two-bit counters indexed by PC xor global history,
// swept to weak-not-taken after reset, then serving one lookup and one update per clock.
module gshare_pht #(
  parameter int IDX_W = 12,
  parameter int GHR_W = 14,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic [GHR_W-1:0] ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic             ready,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  output logic [1:0]       pred_ctr,
  output logic [31:0]      mispredict_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       table_q [DEPTH];

  logic             pov_q, pov_d;
  logic             taken_q, taken_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [1:0]       ctr_q, ctr_d;
  logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;

  logic             run;
  logic [IDX_W-1:0] lookup_idx;
  logic [1:0]       upd_old, upd_new, lookup_ctr;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_data;

  logic unused_bits;
  assign unused_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0], ghr[GHR_W-1:IDX_W]};

  assign run        = (state_q == RUN);
  assign lookup_idx = pred_pc[IDX_W+1:2] ^ ghr[IDX_W-1:0];
  assign upd_old    = table_q[upd_index];

  always_comb begin
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
    end
  end

  // Same-index lookup sees the counter as it will be after this edge's update.
  assign lookup_ctr = (upd_valid && (upd_index == lookup_idx)) ? upd_new : table_q[lookup_idx];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = 2'b01;
    case (state_q)
      INIT: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) state_d = RUN;
      end
      RUN: begin
        if (upd_valid) begin
          wr_en   = 1'b1;
          wr_idx  = upd_index;
          wr_data = upd_new;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    pov_d            = run & pred_valid;
    taken_d          = taken_q;
    index_d          = index_q;
    ctr_d            = ctr_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (run && pred_valid) begin
      taken_d = lookup_ctr[1];
      index_d = lookup_idx;
      ctr_d   = lookup_ctr;
    end
    if (run && upd_valid && upd_mispredict && !(&mispredict_cnt_q))
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= INIT;
      ptr_q            <= '0;
      pov_q            <= 1'b0;
      taken_q          <= 1'b0;
      index_q          <= '0;
      ctr_q            <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      pov_q            <= pov_d;
      taken_q          <= taken_d;
      index_q          <= index_d;
      ctr_q            <= ctr_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Storage has no reset; held in reset it only rewrites entry 0, which the sweep redoes anyway.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_idx] <= wr_data;
  end

  assign ready          = run;
  assign pred_out_valid = pov_q;
  assign pred_taken     = taken_q;
  assign pred_index     = index_q;
  assign pred_ctr       = ctr_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: an abstract table model checked every cycle plus directed literal checks.
module tb_gshare_pht;
  localparam int IDX_W = 12;
  localparam int GHR_W = 14;
  localparam int PC_W  = 32;
  localparam int N     = 4096;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pred_valid = 1'b0;
  logic [PC_W-1:0]  pred_pc = '0;
  logic [GHR_W-1:0] ghr = '0;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_index = '0;
  logic             upd_taken = 1'b0;
  logic             upd_mispredict = 1'b0;
  logic             ready, pred_out_valid, pred_taken;
  logic [IDX_W-1:0] pred_index;
  logic [1:0]       pred_ctr;
  logic [31:0]      mispredict_cnt;

  gshare_pht #(.IDX_W(IDX_W), .GHR_W(GHR_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc), .ghr(ghr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .ready(ready), .pred_out_valid(pred_out_valid),
    .pred_taken(pred_taken), .pred_index(pred_index), .pred_ctr(pred_ctr),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counters as plain integers, readiness as an edge count since reset release.
  int          m_tab [N];
  bit          m_ready;
  int          m_init;
  bit          m_pov, m_taken;
  int          m_idx, m_ctr;
  logic [31:0] m_cnt;
  int          pi;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 0; m_init = 0; m_pov = 0; m_taken = 0; m_idx = 0; m_ctr = 0; m_cnt = 0;
    end else if (!m_ready) begin
      m_pov = 0;
      m_init++;
      if (m_init == N) begin
        m_ready = 1;
        foreach (m_tab[i]) m_tab[i] = 1;
      end
    end else begin
      pi = int'(pred_pc[IDX_W+1:2] ^ ghr[IDX_W-1:0]);
      if (upd_valid) begin
        if (upd_taken) m_tab[upd_index] = (m_tab[upd_index] == 3) ? 3 : m_tab[upd_index] + 1;
        else           m_tab[upd_index] = (m_tab[upd_index] == 0) ? 0 : m_tab[upd_index] - 1;
        if (upd_mispredict && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      m_pov = pred_valid;
      if (pred_valid) begin
        m_idx   = pi;
        m_ctr   = m_tab[pi];
        m_taken = (m_ctr >= 2);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("pred_out_valid", 32'(pred_out_valid), 32'(m_pov));
    chk("pred_taken", 32'(pred_taken), 32'(m_taken));
    chk("pred_index", 32'(pred_index), 32'(m_idx));
    chk("pred_ctr", 32'(pred_ctr), 32'(m_ctr));
    chk("mispredict_cnt", mispredict_cnt, m_cnt);
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input bit pv, input logic [31:0] pc, input logic [13:0] g,
                       input bit uv, input logic [11:0] ui, input bit ut, input bit um);
    pred_valid = pv; pred_pc = pc; ghr = g;
    upd_valid = uv; upd_index = ui; upd_taken = ut; upd_mispredict = um;
    @(posedge clk);
    #3;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pc_of(input int idx);
    return 32'(idx) << 2;
  endfunction

  task automatic run_init(input bit um, input logic [11:0] ui, output int n, output bit saw);
    n = 0; saw = 0;
    while (!ready && n < 5000) begin
      drive(1, pc_of(n % N), 14'h0, um, ui, 1, um);
      if (pred_out_valid) saw = 1;
      n++;
    end
  endtask

  int n_edges;
  bit saw_pov;
  int exp_ctr [4] = '{2, 3, 3, 3};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset pred_ctr", 32'(pred_ctr), 32'd0);
    rst = 1'b0;
    run_init(0, 12'h0, n_edges, saw_pov);
    chk("init edge count", 32'(n_edges), 32'd4096);
    chk("init no pred_out_valid", 32'(saw_pov), 32'd0);

    drive(1, pc_of(12'h0AA), 14'h0, 0, 0, 0, 0);
    chk("first lookup valid", 32'(pred_out_valid), 32'd1);
    chk("first lookup ctr", 32'(pred_ctr), 32'd1);
    chk("first lookup taken", 32'(pred_taken), 32'd0);

    drive(1, 32'h0000_1010, 14'h0004, 0, 0, 0, 0);
    chk("hash index", 32'(pred_index), 32'h400);
    drive(0, 32'h0, 14'h0, 0, 0, 0, 0);
    chk("hold valid low", 32'(pred_out_valid), 32'd0);
    chk("hold index", 32'(pred_index), 32'h400);

    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 12'h123, 1, 0);
      drive(1, pc_of(12'h123), 14'h0, 0, 0, 0, 0);
      chk("train up ctr", 32'(pred_ctr), 32'(exp_ctr[k]));
    end
    chk("train up taken", 32'(pred_taken), 32'd1);
    repeat (3) drive(0, 0, 0, 1, 12'h123, 0, 0);
    drive(1, pc_of(12'h123), 14'h0, 0, 0, 0, 0);
    chk("train down ctr", 32'(pred_ctr), 32'd0);
    drive(0, 0, 0, 1, 12'h123, 0, 0);
    drive(1, pc_of(12'h123), 14'h0, 0, 0, 0, 0);
    chk("floor ctr", 32'(pred_ctr), 32'd0);

    drive(1, pc_of(12'h055), 14'h0, 1, 12'h055, 1, 0);
    chk("collision ctr", 32'(pred_ctr), 32'd2);
    chk("collision taken", 32'(pred_taken), 32'd1);

    drive(1, pc_of(12'h200), 14'h0, 1, 12'h201, 1, 1);
    chk("split pred ctr", 32'(pred_ctr), 32'd1);
    chk("split mispredict", mispredict_cnt, 32'd1);
    drive(1, pc_of(12'h201), 14'h0, 0, 0, 0, 0);
    chk("split upd ctr", 32'(pred_ctr), 32'd2);

    force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_cnt_q;
    drive(0, 0, 0, 1, 12'h300, 0, 1);
    chk("cnt near sat", mispredict_cnt, 32'hFFFF_FFFF);
    drive(0, 0, 0, 1, 12'h300, 0, 1);
    chk("cnt saturated", mispredict_cnt, 32'hFFFF_FFFF);

    drive(0, 0, 0, 1, 12'h077, 1, 0);
    drive(0, 0, 0, 1, 12'h077, 1, 0);
    drive(1, pc_of(12'h077), 14'h0, 0, 0, 0, 0);
    chk("trained 077", 32'(pred_ctr), 32'd3);
    repeat (100) drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst pov", 32'(pred_out_valid), 32'd0);
    chk("rst taken", 32'(pred_taken), 32'd0);
    chk("rst index", 32'(pred_index), 32'd0);
    chk("rst ctr", 32'(pred_ctr), 32'd0);
    chk("rst cnt", mispredict_cnt, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    run_init(1, 12'h077, n_edges, saw_pov);
    chk("reinit edge count", 32'(n_edges), 32'd4096);
    chk("reinit no pred_out_valid", 32'(saw_pov), 32'd0);
    chk("init mispredicts ignored", mispredict_cnt, 32'd0);
    drive(1, pc_of(12'h077), 14'h0, 0, 0, 0, 0);
    chk("077 after reinit", 32'(pred_ctr), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
